cmem_line_buffer: RTL and testbench
===================================

Name: cmem_line_buffer

Overview:
- Responder side of the cmem word interface: accepts 32-bit word read/write requests and serves them from a single 256-bit line buffer.
- Write-back, write-allocate, one line deep.
- Sits between one CPU cmem port (instruction or data) and the 256-bit line-wide pmem interface.
- Cache-hit latency: 0 cycles. Misses fetch the line over pmem and write back a dirty line first.

Parameters:
- LINE_OFFSET_W, 5, byte-offset bits per line (32-byte line, 8 words). Fixed; the tag is addr[31:LINE_OFFSET_W].

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cmem_read  in  1  word read request, held until cmem_resp
- cmem_write  in  1  word write request, held until cmem_resp
- cmem_byte_enable  in  4  byte lanes for writes; ignored on reads
- cmem_address  in  32  byte address; [4:2] selects the word, [1:0] ignored
- cmem_wdata  in  32  write data
- cmem_resp  out  1  request completed this cycle
- cmem_rdata  out  32  read data, valid when cmem_resp=1
- pmem_read  out  1  line fetch request, held until pmem_resp
- pmem_write  out  1  line writeback request, held until pmem_resp
- pmem_address  out  32  line-aligned address ([4:0]=0)
- pmem_wdata  out  256  writeback line data
- pmem_rdata  in  256  fetched line data, valid with pmem_resp
- pmem_resp  in  1  pmem transaction complete

Behaviour:
- State registers:
  - valid, dirty
  - tag[26:0]
  - line[255:0]
  - miss_addr[31:5]
  - FSM state in {IDLE, WRITEBACK, FILL}
- Reset (async, rst_n=0):
  - state=IDLE, valid=0, dirty=0.
  - All outputs deassert immediately: cmem_resp=0, pmem_read=0, pmem_write=0.
  - cmem_rdata, pmem_address and pmem_wdata are don't-care but must be driven (no X propagation into strobes).
  - tag and line are not reset.
- req = cmem_read | cmem_write. hit = valid & (tag == cmem_address[31:5]).
- IDLE:
  - req & hit:
    - cmem_resp=1 combinationally in the same cycle.
    - cmem_rdata = line word at address[4:2].
    - If the request is a write, at that edge each enabled byte of the selected word is updated and dirty is set.
  - req & !hit: capture miss_addr = cmem_address[31:5]. Next state is WRITEBACK if valid & dirty, otherwise FILL. cmem_resp=0.
  - No req: stay in IDLE, all strobes low.
- WRITEBACK:
  - pmem_write=1, pmem_address={tag,5'b0}, pmem_wdata=line.
  - On pmem_resp: dirty<=0, go to FILL.
- FILL:
  - pmem_read=1, pmem_address={miss_addr,5'b0}.
  - On pmem_resp: line<=pmem_rdata, tag<=miss_addr, valid<=1, dirty<=0, go to IDLE.
- After a fill, the held request hits in the next cycle (miss latency = pmem latencies + 1 cycle).
- cmem_resp is asserted only in IDLE. pmem_read and pmem_write are never high together.
- Request withdrawn during WRITEBACK/FILL: the transaction completes and the line is installed; no cmem_resp is issued.
- Address change during a miss: the fill uses miss_addr. The new address is re-evaluated in IDLE and may miss again.
- cmem_read & cmem_write both high: treated as a write; cmem_rdata still returns the pre-write word.
- Write with byte_enable=0000 on a hit: cmem_resp=1, line unchanged, dirty still set.
- pmem_resp while in IDLE: ignored.

Test Plan:
- Reset, then read 0x0000_0104 with pmem_rdata = words 0..7 = 0x1000+i, pmem_resp after 3 cycles -> one pmem_read at 0x0000_0100, no pmem_write; cmem_resp on the cycle after fill with cmem_rdata=0x1001.
- Hit read 0x0000_011C, then write 0x0000_0108 data 0xAABBCCDD be=0101 over 0x1002 -> read 0x011C returns 0x1007 with resp same cycle; a following read of 0x0108 returns 0x00BB10DD; dirty=1.
- Dirty line, read 0x0000_2000 -> pmem_write at 0x0000_0100 with wdata word2=0x00BB10DD, then pmem_read at 0x0000_2000; cmem_resp only after both pmem_resp.
- Clean line (right after a fill), miss at 0x0000_4000 -> no pmem_write; pmem_read directly at 0x0000_4000.
- Drop cmem_read in the middle of FILL -> no cmem_resp; a later read of the same line hits with 0 wait cycles.
- Assert rst_n=0 during WRITEBACK -> pmem_write falls with no clock edge needed; after release, a read of the prior line misses (valid=0).

Source files
------------

// File: rtl/cmem_line_buffer_if.sv
// Bus bundle for cmem_line_buffer: the cmem word port on one side, the pmem line port on the other.
// slave is the line buffer; master is the CPU plus memory environment around it.
interface cmem_line_buffer_if;
    logic         cmem_read;
    logic         cmem_write;
    logic [3:0]   cmem_byte_enable;
    logic [31:0]  cmem_address;
    logic [31:0]  cmem_wdata;
    logic         cmem_resp;
    logic [31:0]  cmem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    // Handshake: a cmem request (read/write) is held until the cycle cmem_resp is high;
    // a pmem request (read/write) is held until the cycle pmem_resp is high.
    modport slave (
        input  cmem_read, cmem_write, cmem_byte_enable, cmem_address, cmem_wdata,
        output cmem_resp, cmem_rdata,
        output pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  pmem_rdata, pmem_resp
    );

    modport master (
        output cmem_read, cmem_write, cmem_byte_enable, cmem_address, cmem_wdata,
        input  cmem_resp, cmem_rdata,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata,
        output pmem_rdata, pmem_resp
    );
endinterface

// File: rtl/cmem_line_buffer.sv
// One-line write-back, write-allocate buffer serving 32-bit cmem words from a 256-bit pmem line.
// Hits respond combinationally; misses write back a dirty line, then fill.
module cmem_line_buffer #(
    parameter int LINE_OFFSET_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    cmem_line_buffer_if.slave bus,
    output logic [1:0]        dbg_state_o,
    output logic              dbg_valid_o,
    output logic              dbg_dirty_o
);
    localparam int TAG_W = 32 - LINE_OFFSET_W;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         valid_q, valid_d;
    logic         dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [TAG_W-1:0] miss_addr_q, miss_addr_d;
    logic [255:0] line_q, line_d;

    logic         req;
    logic         hit;
    logic [2:0]   word_sel;
    logic         unused_addr_lsb;

    assign req             = bus.cmem_read | bus.cmem_write;
    assign hit             = valid_q & (tag_q == bus.cmem_address[31:LINE_OFFSET_W]);
    assign word_sel        = bus.cmem_address[4:2];
    assign unused_addr_lsb = ^bus.cmem_address[1:0];

    assign dbg_state_o = state_q;
    assign dbg_valid_o = valid_q;
    assign dbg_dirty_o = dirty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            valid_q     <= 1'b0;
            dirty_q     <= 1'b0;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    // Tag and line data carry no reset; valid_q guards every use of them.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

    always_comb begin
        state_d          = state_q;
        valid_d          = valid_q;
        dirty_d          = dirty_q;
        tag_d            = tag_q;
        miss_addr_d      = miss_addr_q;
        line_d           = line_q;
        bus.cmem_resp    = 1'b0;
        bus.cmem_rdata   = line_q[{word_sel, 5'b00000} +: 32];
        bus.pmem_read    = 1'b0;
        bus.pmem_write   = 1'b0;
        bus.pmem_address = {miss_addr_q, {LINE_OFFSET_W{1'b0}}};
        bus.pmem_wdata   = line_q;

        unique case (state_q)
            IDLE: begin
                if (req && hit) begin
                    bus.cmem_resp = 1'b1;
                    // A simultaneous read+write is a write; rdata above still shows the old word.
                    if (bus.cmem_write) begin
                        dirty_d = 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (bus.cmem_byte_enable[b]) begin
                                line_d[{word_sel, b[1:0], 3'b000} +: 8] = bus.cmem_wdata[b*8 +: 8];
                            end
                        end
                    end
                end else if (req) begin
                    miss_addr_d = bus.cmem_address[31:LINE_OFFSET_W];
                    state_d     = (valid_q && dirty_q) ? WRITEBACK : FILL;
                end
            end
            WRITEBACK: begin
                bus.pmem_write   = 1'b1;
                bus.pmem_address = {tag_q, {LINE_OFFSET_W{1'b0}}};
                if (bus.pmem_resp) begin
                    dirty_d = 1'b0;
                    state_d = FILL;
                end
            end
            FILL: begin
                bus.pmem_read = 1'b1;
                if (bus.pmem_resp) begin
                    line_d  = bus.pmem_rdata;
                    tag_d   = miss_addr_q;
                    valid_d = 1'b1;
                    dirty_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_cmem_line_buffer.sv
// Directed bench for cmem_line_buffer: fills, hits, byte writes, dirty writeback and reset mid-transaction.
module tb_cmem_line_buffer;
    logic clk;
    logic rst_n;
    logic [1:0] dbg_state;
    logic dbg_valid;
    logic dbg_dirty;

    int checks = 0;
    int errors = 0;
    int rd_starts = 0;
    int wr_starts = 0;
    logic prev_rd = 1'b0;
    logic prev_wr = 1'b0;

    cmem_line_buffer_if bus ();

    cmem_line_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state),
        .dbg_valid_o (dbg_valid),
        .dbg_dirty_o (dbg_dirty)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Counts pmem request starts and guards the read/write exclusivity.
    always @(negedge clk) begin
        if (bus.pmem_read && !prev_rd) rd_starts++;
        if (bus.pmem_write && !prev_wr) wr_starts++;
        prev_rd = bus.pmem_read;
        prev_wr = bus.pmem_write;
        if (rst_n) chk("pmem_rd_wr_exclusive", {31'd0, bus.pmem_read & bus.pmem_write}, 32'd0);
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be);
        bus.cmem_read        = rd;
        bus.cmem_write       = wr;
        bus.cmem_address     = addr;
        bus.cmem_wdata       = wdata;
        bus.cmem_byte_enable = be;
        #1;
    endtask

    task automatic load_line(input logic [31:0] base);
        for (int i = 0; i < 8; i++) bus.pmem_rdata[i*32 +: 32] = base + i[31:0];
    endtask

    task automatic pmem_ack();
        bus.pmem_resp = 1'b1;
        tick();
        bus.pmem_resp = 1'b0;
        #1;
    endtask

    task automatic wait_state(input string tag, input logic [1:0] st, input int budget);
        int n = 0;
        while (dbg_state !== st && n < budget) begin
            tick();
            n++;
        end
        chk(tag, {30'd0, dbg_state}, {30'd0, st});
    endtask

    initial begin
        rst_n = 1'b0;
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        chk("rst_cmem_resp", {31'd0, bus.cmem_resp}, 32'd0);
        chk("rst_pmem_read", {31'd0, bus.pmem_read}, 32'd0);
        chk("rst_pmem_write", {31'd0, bus.pmem_write}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        chk("rst_valid", {31'd0, dbg_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Cold miss on 0x104, fill returns 0x1000+i after 3 cycles.
        load_line(32'h1000);
        set_req(1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'h0);
        chk("miss_no_resp", {31'd0, bus.cmem_resp}, 32'd0);
        tick();
        chk("fill1_pmem_read", {31'd0, bus.pmem_read}, 32'd1);
        chk("fill1_addr", bus.pmem_address, 32'h0000_0100);
        chk("fill1_no_write", {31'd0, bus.pmem_write}, 32'd0);
        tick();
        tick();
        chk("fill1_no_resp_wait", {31'd0, bus.cmem_resp}, 32'd0);
        pmem_ack();
        chk("fill1_resp", {31'd0, bus.cmem_resp}, 32'd1);
        chk("fill1_rdata", bus.cmem_rdata, 32'h0000_1001);
        chk("fill1_pmem_idle", {31'd0, bus.pmem_read}, 32'd0);
        chk("fill1_rd_count", rd_starts, 32'd1);
        chk("fill1_wr_count", wr_starts, 32'd0);
        tick();

        // Hits: read, byte write, read back, read+write with no lanes.
        set_req(1'b1, 1'b0, 32'h0000_011C, 32'h0, 4'h0);
        chk("hit_resp", {31'd0, bus.cmem_resp}, 32'd1);
        chk("hit_rdata_11c", bus.cmem_rdata, 32'h0000_1007);
        tick();
        set_req(1'b0, 1'b1, 32'h0000_0108, 32'hAABB_CCDD, 4'b0101);
        chk("wr_resp", {31'd0, bus.cmem_resp}, 32'd1);
        tick();
        set_req(1'b1, 1'b0, 32'h0000_0108, 32'h0, 4'h0);
        chk("wr_readback", bus.cmem_rdata, 32'h00BB_10DD);
        chk("wr_dirty", {31'd0, dbg_dirty}, 32'd1);
        tick();
        set_req(1'b1, 1'b1, 32'h0000_010C, 32'hFFFF_FFFF, 4'b0000);
        chk("rw_resp", {31'd0, bus.cmem_resp}, 32'd1);
        chk("rw_old_word", bus.cmem_rdata, 32'h0000_1003);
        tick();
        set_req(1'b1, 1'b0, 32'h0000_010C, 32'h0, 4'h0);
        chk("be0_unchanged", bus.cmem_rdata, 32'h0000_1003);
        tick();

        // Dirty miss at 0x2000: writeback then fill.
        load_line(32'h2000);
        set_req(1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'h0);
        tick();
        chk("wb_pmem_write", {31'd0, bus.pmem_write}, 32'd1);
        chk("wb_addr", bus.pmem_address, 32'h0000_0100);
        chk("wb_word2", bus.pmem_wdata[95:64], 32'h00BB_10DD);
        chk("wb_word0", bus.pmem_wdata[31:0], 32'h0000_1000);
        chk("wb_no_resp", {31'd0, bus.cmem_resp}, 32'd0);
        tick();
        chk("wb_held", {31'd0, bus.pmem_write}, 32'd1);
        pmem_ack();
        chk("wb_then_read", {31'd0, bus.pmem_read}, 32'd1);
        chk("wb_fill_addr", bus.pmem_address, 32'h0000_2000);
        chk("wb_fill_no_resp", {31'd0, bus.cmem_resp}, 32'd0);
        pmem_ack();
        chk("wb_final_resp", {31'd0, bus.cmem_resp}, 32'd1);
        chk("wb_final_rdata", bus.cmem_rdata, 32'h0000_2000);
        chk("wb_rd_count", rd_starts, 32'd2);
        chk("wb_wr_count", wr_starts, 32'd1);
        tick();

        // Clean miss at 0x4000, request dropped mid-fill.
        load_line(32'h4000);
        set_req(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
        tick();
        chk("clean_no_write", {31'd0, bus.pmem_write}, 32'd0);
        chk("clean_read", {31'd0, bus.pmem_read}, 32'd1);
        chk("clean_addr", bus.pmem_address, 32'h0000_4000);
        set_req(1'b0, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
        tick();
        pmem_ack();
        chk("drop_no_resp", {31'd0, bus.cmem_resp}, 32'd0);
        chk("drop_valid", {31'd0, dbg_valid}, 32'd1);
        chk("drop_wr_count", wr_starts, 32'd1);
        tick();
        set_req(1'b1, 1'b0, 32'h0000_4014, 32'h0, 4'h0);
        chk("drop_hit_resp", {31'd0, bus.cmem_resp}, 32'd1);
        chk("drop_hit_rdata", bus.cmem_rdata, 32'h0000_4005);
        tick();

        // Stray pmem_resp in IDLE.
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        pmem_ack();
        chk("stray_resp_state", {30'd0, dbg_state}, 32'd0);
        chk("stray_resp_read", {31'd0, bus.pmem_read}, 32'd0);

        // Reset during writeback.
        set_req(1'b0, 1'b1, 32'h0000_4000, 32'h1234_5678, 4'b1111);
        tick();
        set_req(1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'h0);
        wait_state("rst_wb_enter", 2'd1, 5);
        chk("rst_wb_write", {31'd0, bus.pmem_write}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_wb_async_drop", {31'd0, bus.pmem_write}, 32'd0);
        chk("rst_wb_state", {30'd0, dbg_state}, 32'd0);
        tick();
        rst_n = 1'b1;
        set_req(1'b1, 1'b0, 32'h0000_4000, 32'h0, 4'h0);
        chk("post_rst_miss", {31'd0, bus.cmem_resp}, 32'd0);
        tick();
        chk("post_rst_no_write", {31'd0, bus.pmem_write}, 32'd0);
        chk("post_rst_read", {31'd0, bus.pmem_read}, 32'd1);
        chk("post_rst_addr", bus.pmem_address, 32'h0000_4000);
        pmem_ack();
        chk("post_rst_resp", {31'd0, bus.cmem_resp}, 32'd1);
        chk("post_rst_rdata", bus.cmem_rdata, 32'h0000_4000);
        set_req(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
